voter_ctrl: RTL and testbench
=============================

# voter_ctrl

Sequencing controller for the four-member voting datapath. It opens a voting session on `start` and collects at most one ballot per member through per-member valid strobes. It closes the session when all four members have voted or a timeout expires, then evaluates the tally using the team's reject/tie/pass encoding. The block sits between the member input front-end and the result display, and replaces free-running combinational voting with a framed, one-ballot-per-member session.

## Interface
Parameters:
- `TIMEOUT`, default 100: number of COLLECT cycles before the session is forced closed. Must be ≥ 1.
- `CW`, default 8: width of the session timer. Must satisfy 2^CW > TIMEOUT-1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  opens a session; sampled only in IDLE.
- `vld`  in  4  `vld[k]=1` means member k presents a ballot this cycle.
- `vote`  in  4  `vote[k]` is member k's ballot (1 = yes); qualified by `vld[k]`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `voted`  out  4  `voted[k]=1` once member k's ballot has been accepted in the current session.
- `O`  out  3 (`[3:1]`)  result: 100 = reject, 010 = tie, 001 = pass, 000 = no result.
- `done`  out  1  one-cycle pulse; `O` is valid from this cycle onward.
- `sessions`  out  8  count of completed sessions; wraps from 255 to 0.

## Operation
- **States:** IDLE, COLLECT, EVAL, DONE. All outputs are registered.
- **Reset values:** state = IDLE; `O` = 000; `done` = 0; `busy` = 0; `voted` = 0000; internal yes register = 0000; timer = 0; `sessions` = 0.
- **IDLE:** `start` = 1 moves to COLLECT. On the same edge, clear `voted`, the yes register and the timer, and set `O` to 000. `vld` is ignored in IDLE, including in the `start` cycle.
- **COLLECT:** for each k with `vld[k]` = 1 and `voted[k]` = 0, set `voted[k]` to 1 and `yes[k]` to `vote[k]`.
  - Ballots from members already voted are ignored; first ballot wins.
  - The timer increments once per COLLECT cycle.
  - Exit to EVAL when `(voted | accepted_this_cycle)` = 1111, or when timer = TIMEOUT-1.
  - Ballots accepted in the exit cycle count.
  - `start` is ignored in COLLECT.
- **Absent members:** a member who never votes counts as "no" (yes bit stays 0).
- **EVAL:** tally = popcount(yes), 0..4, 3-bit unsigned.
  - 0 or 1 gives `O` = 100; 2 gives `O` = 010; 3 or 4 gives `O` = 001.
  - `O` and `sessions` (+1, mod 256) update on the EVAL→DONE edge.
- **DONE:** `done` = 1 for exactly one cycle, then unconditional return to IDLE. `start` is ignored in DONE.
- **Holding:** `O` and `voted` hold their values through IDLE until the next accepted `start`.
- **Reset mid-session:** return immediately to IDLE with reset values. The partial session does not increment `sessions`.

## Timing
- Let E0 be the edge sampling `start`, and N the number of COLLECT cycles (1 ≤ N ≤ TIMEOUT).
- COLLECT occupies cycles 1..N, EVAL is cycle N+1, and DONE (`done` = 1, new `O`) is cycle N+2.
- **Minimum latency:** all four ballots arrive in cycle 1, so `done` is high in cycle 3.
- **Maximum latency:** the session times out, so `done` is high in cycle TIMEOUT+2.
- `busy` rises in cycle 1 and falls in cycle N+3, when the block is back in IDLE.
- A new `start` is accepted no earlier than cycle N+3.
- `voted` reflects accepted ballots one cycle after the `vld` cycle.

## Test plan
- **Reset:** assert `rst_n` = 0 asynchronously mid-cycle → all outputs read 0 immediately, before the next clock edge.
- **Fast pass:** `start`, then in cycle 1 drive `vld` = 1111, `vote` = 0111 → `done` = 1 in cycle 3, `O` = 001, `voted` = 1111, `sessions` = 1.
- **Staggered tie and duplicates:**
  - cycle 1: `vld` = 1100, `vote` = 1000; cycle 2: `vld` = 0011, `vote` = 0001; cycle 3: `vld` = 1000, `vote` = 0000.
  - Expected: exit after cycle 2, `done` in cycle 4, `O` = 010. The member-3 re-vote is ignored because EVAL has already been entered.
- **Timeout (TIMEOUT = 8):** only `vld` = 0001, `vote` = 0001 in cycle 1 → `done` in cycle 10, `O` = 100, `voted` = 0001. A `start` pulse in cycle 5 is ignored.
- **Re-vote ignored:** member 1 votes yes in cycle 1 and no in cycle 2; members 0 and 2 vote yes in cycle 3; member 3 votes no in cycle 3 → tally 3, `O` = 001.
- **Reset and wrap:**
  - Deassert `rst_n` during COLLECT → IDLE, `O` = 000, `sessions` unchanged at 0.
  - Run 256 complete sessions → `sessions` wraps from 255 to 0.

Source files
------------

// File: rtl/voter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : voter_ctrl
// Brief    : Framed four-member voting session: collect one ballot per member
//            until all have voted or the timer expires, then publish the tally.
// Revision : 1.0 - initial release
// ============================================================================
module voter_ctrl #(
    parameter int TIMEOUT = 100,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] vld,
    input  logic [3:0] vote,
    output logic       busy,
    output logic [3:0] voted,
    output logic [3:1] O,
    output logic       done,
    output logic [7:0] sessions
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_tmax = CW'(TIMEOUT - 1);

    state_t        r_state, w_next_state;
    logic [3:0]    r_voted, w_voted_nx;
    logic [3:0]    r_yes, w_yes_nx;
    logic [CW-1:0] r_timer, w_timer_nx;
    logic [3:1]    r_o, w_o_nx;
    logic [7:0]    r_sessions, w_sessions_nx;
    logic          r_busy, r_done;
    logic [3:0]    w_accept;
    logic [2:0]    w_tally;

    assign w_accept = vld & ~r_voted;
    assign w_tally  = 3'(r_yes[0]) + 3'(r_yes[1]) + 3'(r_yes[2]) + 3'(r_yes[3]);

    always_comb begin
        w_next_state  = r_state;
        w_voted_nx    = r_voted;
        w_yes_nx      = r_yes;
        w_timer_nx    = r_timer;
        w_o_nx        = r_o;
        w_sessions_nx = r_sessions;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_COLLECT;
                    w_voted_nx   = 4'b0000;
                    w_yes_nx     = 4'b0000;
                    w_timer_nx   = '0;
                    w_o_nx       = 3'b000;
                end
            end
            S_COLLECT: begin
                // First ballot per member wins; later ones are masked by r_voted.
                w_voted_nx = r_voted | w_accept;
                w_yes_nx   = (r_yes & ~w_accept) | (vote & w_accept);
                w_timer_nx = r_timer + 1'b1;
                if (((r_voted | w_accept) == 4'b1111) || (r_timer == c_tmax))
                    w_next_state = S_EVAL;
            end
            S_EVAL: begin
                if (w_tally <= 3'd1)
                    w_o_nx = 3'b100;
                else if (w_tally == 3'd2)
                    w_o_nx = 3'b010;
                else
                    w_o_nx = 3'b001;
                w_sessions_nx = r_sessions + 8'd1;
                w_next_state  = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_voted    <= 4'b0000;
            r_yes      <= 4'b0000;
            r_timer    <= '0;
            r_o        <= 3'b000;
            r_sessions <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_voted    <= w_voted_nx;
            r_yes      <= w_yes_nx;
            r_timer    <= w_timer_nx;
            r_o        <= w_o_nx;
            r_sessions <= w_sessions_nx;
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (w_next_state == S_DONE);
        end
    end

    assign busy     = r_busy;
    assign voted    = r_voted;
    assign O        = r_o;
    assign done     = r_done;
    assign sessions = r_sessions;

endmodule
`default_nettype wire

// File: tb/tb_voter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_voter_ctrl
// Brief    : Self-checking bench for voter_ctrl: vector table, reset cases,
//            randomized sessions against a ballot-level model, counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voter_ctrl;

    localparam int TO   = 8;
    localparam int MAXC = TO + 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] vld   = 4'h0;
    logic [3:0] vote  = 4'h0;
    logic       busy;
    logic [3:0] voted;
    logic [3:1] O;
    logic       done;
    logic [7:0] sessions;

    voter_ctrl #(.TIMEOUT(TO), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vld(vld), .vote(vote),
        .busy(busy), .voted(voted), .O(O), .done(done), .sessions(sessions)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] s_vld  [1:MAXC];
    logic [3:0] s_vote [1:MAXC];
    logic       s_start[1:MAXC];
    logic [MAXC:1] busy_log, done_log;
    logic [3:0] voted_log[1:MAXC];
    logic [3:1] o_at_done;
    logic [3:0] voted_at_done;
    logic [7:0] sess_at_done;
    int         done_cyc;
    logic [7:0] exp_sess = 8'd0;
    int         m_first[4];

    typedef struct {
        logic [0:2][3:0] v;
        logic [0:2][3:0] b;
        int              st;
        logic [3:1]      o;
        int              dc;
        logic [3:0]      vf;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched;
        for (int k = 1; k <= MAXC; k++) begin
            s_vld[k] = 4'h0; s_vote[k] = 4'h0; s_start[k] = 1'b0;
        end
    endtask

    task automatic log_cycle(input int k);
        busy_log[k]  = busy;
        done_log[k]  = done;
        voted_log[k] = voted;
        if (done && done_cyc == 0) begin
            done_cyc      = k;
            o_at_done     = O;
            voted_at_done = voted;
            sess_at_done  = sessions;
        end
    endtask

    // Cycle k is the interval after the k-th edge following the start edge.
    task automatic run_session;
        done_cyc = 0; o_at_done = 3'b000; voted_at_done = 4'h0; sess_at_done = 8'd0;
        start = 1'b1; vld = 4'($urandom); vote = 4'($urandom);
        step;
        start = 1'b0;
        log_cycle(1);
        for (int k = 1; k < MAXC; k++) begin
            vld = s_vld[k]; vote = s_vote[k]; start = s_start[k];
            step;
            log_cycle(k + 1);
        end
        vld = 4'h0; vote = 4'h0; start = 1'b0;
    endtask

    // Ballot-level model: first ballot per member, session length, tally.
    task automatic model(output int n, output logic [3:1] o);
        int tally;
        for (int m = 0; m < 4; m++) m_first[m] = 0;
        n = TO;
        for (int k = 1; k <= TO; k++) begin
            int cnt = 0;
            for (int m = 0; m < 4; m++) begin
                if (s_vld[k][m] && m_first[m] == 0) m_first[m] = k;
                if (m_first[m] != 0) cnt++;
            end
            if (cnt == 4) begin
                n = k;
                break;
            end
        end
        tally = 0;
        for (int m = 0; m < 4; m++)
            if (m_first[m] != 0 && s_vote[m_first[m]][m]) tally++;
        o = (tally <= 1) ? 3'b100 : (tally == 2) ? 3'b010 : 3'b001;
    endtask

    task automatic check_session(input int n, input logic [3:1] o);
        logic [MAXC:1] eb, ed;
        for (int k = 1; k <= MAXC; k++) begin
            logic [3:0] ev = 4'h0;
            eb[k] = (k <= n + 2);
            ed[k] = (k == n + 2);
            for (int m = 0; m < 4; m++)
                if (m_first[m] != 0 && m_first[m] < k && m_first[m] <= n) ev[m] = 1'b1;
            chk($sformatf("voted_c%0d", k), 32'(voted_log[k]), 32'(ev));
        end
        chk("done_cycle", done_cyc, n + 2);
        chk("busy_trace", 32'(busy_log), 32'(eb));
        chk("done_trace", 32'(done_log), 32'(ed));
        chk("result", 32'(o_at_done), 32'(o));
        chk("sessions", 32'(sess_at_done), 32'(exp_sess));
        chk("o_hold", 32'(O), 32'(o));
    endtask

    initial begin
        int n;
        logic [3:1] eo;

        // Reset state, asserted asynchronously before any edge
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_o", 32'(O), 0);
        chk("rst_voted", 32'(voted), 0);
        chk("rst_sess", 32'(sessions), 0);
        #4 rst_n = 1'b1;
        step;

        // Mid-COLLECT async reset
        start = 1'b1; step; start = 1'b0;
        vld = 4'b0011; vote = 4'b0011; step; vld = 4'h0;
        chk("pre_rst_voted", 32'(voted), 32'h3);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_voted", 32'(voted), 0);
        chk("mid_rst_o", 32'(O), 0);
        chk("mid_rst_sess", 32'(sessions), 0);
        #2 rst_n = 1'b1;
        step;
        chk("post_rst_busy", 32'(busy), 0);

        // Directed vector table
        vecs[0] = '{v: {4'hF, 4'h0, 4'h0}, b: {4'h7, 4'h0, 4'h0}, st: 0, o: 3'b001, dc: 3,  vf: 4'hF};
        vecs[1] = '{v: {4'hC, 4'h3, 4'h8}, b: {4'h8, 4'h1, 4'h0}, st: 0, o: 3'b010, dc: 4,  vf: 4'hF};
        vecs[2] = '{v: {4'h1, 4'h0, 4'h0}, b: {4'h1, 4'h0, 4'h0}, st: 5, o: 3'b100, dc: 10, vf: 4'h1};
        vecs[3] = '{v: {4'h2, 4'h2, 4'hD}, b: {4'h2, 4'h0, 4'h5}, st: 0, o: 3'b001, dc: 5,  vf: 4'hF};
        vecs[4] = '{v: {4'hF, 4'h0, 4'h0}, b: {4'h0, 4'h0, 4'h0}, st: 0, o: 3'b100, dc: 3,  vf: 4'hF};
        vecs[5] = '{v: {4'h5, 4'hA, 4'h0}, b: {4'h5, 4'hA, 4'h0}, st: 0, o: 3'b001, dc: 4,  vf: 4'hF};
        vecs[6] = '{v: {4'hF, 4'h0, 4'h0}, b: {4'h9, 4'h0, 4'h0}, st: 0, o: 3'b010, dc: 3,  vf: 4'hF};
        for (int i = 0; i < 7; i++) begin
            clear_sched;
            for (int k = 0; k < 3; k++) begin
                s_vld[k + 1]  = vecs[i].v[k];
                s_vote[k + 1] = vecs[i].b[k];
            end
            if (vecs[i].st != 0) s_start[vecs[i].st] = 1'b1;
            exp_sess++;
            run_session;
            chk($sformatf("vec%0d_done_cycle", i), done_cyc, vecs[i].dc);
            chk($sformatf("vec%0d_o", i), 32'(o_at_done), 32'(vecs[i].o));
            chk($sformatf("vec%0d_voted", i), 32'(voted_at_done), 32'(vecs[i].vf));
            chk($sformatf("vec%0d_sess", i), 32'(sess_at_done), 32'(exp_sess));
            chk($sformatf("vec%0d_idle", i), 32'(busy_log[vecs[i].dc + 1]), 0);
        end

        // Randomized sessions against the model
        for (int s = 0; s < 80; s++) begin
            int dens;
            clear_sched;
            dens = $urandom_range(1, 6);
            for (int k = 1; k < MAXC; k++) begin
                for (int m = 0; m < 4; m++)
                    s_vld[k][m] = ($urandom_range(0, 15) < dens);
                s_vote[k] = 4'($urandom);
            end
            model(n, eo);
            for (int k = 1; k <= n + 2; k++) s_start[k] = ($urandom_range(0, 7) == 0);
            exp_sess++;
            run_session;
            check_session(n, eo);
        end

        // Reset with a nonzero session count clears it
        #3 rst_n = 1'b0;
        #1 chk("rst2_sess", 32'(sessions), 0);
        chk("rst2_o", 32'(O), 0);
        #2 rst_n = 1'b1;
        step;
        exp_sess = 8'd0;

        // 256 sessions: counter wraps 255 -> 0
        clear_sched;
        s_vld[1] = 4'hF;
        s_vote[1] = 4'hE;
        for (int i = 1; i <= 256; i++) begin
            exp_sess++;
            run_session;
            chk("wrap_sess", 32'(sess_at_done), 32'(exp_sess));
            if (i == 255) chk("wrap_255", 32'(sessions), 255);
            if (i == 256) chk("wrap_0", 32'(sessions), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
